// File: rtl/beta_pkg.sv
// -----------------------------------------------------------------------------
// beta_pkg
// Shared constants and helpers for the Beta execute stage.
//   RESET/ILLOP/XADR : architectural vector addresses
//   NOP              : ADD(R31,R31,R31), the bubble word
//   BNE              : BNE(R31,0,XP), the trap word injected on irsrc=1
//   alu_fn_e         : 4-bit ALU function codes
//   OPC_CLASS_*      : ir[31:30] values that carry an explicit ALU function
// -----------------------------------------------------------------------------
package beta_pkg;

   localparam logic [31:0] RESET = 32'h8000_0000;
   localparam logic [31:0] ILLOP = 32'h8000_0004;
   localparam logic [31:0] XADR  = 32'h8000_0008;
   localparam logic [31:0] NOP   = 32'h83FF_F800;
   localparam logic [31:0] BNE   = 32'h7BDF_0000;

   // ir[31:30] = 10 is register-register, 11 is register-constant.
   localparam logic [1:0] OPC_CLASS_OP  = 2'b10;
   localparam logic [1:0] OPC_CLASS_OPC = 2'b11;

   typedef enum logic [3:0] {
      FN_ADD   = 4'b0000,
      FN_SUB   = 4'b0001,
      FN_MUL   = 4'b0010,
      FN_DIV   = 4'b0011,
      FN_CMPEQ = 4'b0100,
      FN_CMPLT = 4'b0101,
      FN_CMPLE = 4'b0110,
      FN_AND   = 4'b1000,
      FN_OR    = 4'b1001,
      FN_XOR   = 4'b1010,
      FN_XNOR  = 4'b1011,
      FN_SHL   = 4'b1100,
      FN_SHR   = 4'b1101,
      FN_SRA   = 4'b1110
   } alu_fn_e;

   // Memory, branch and illegal opcodes all need a+b (address arithmetic).
   function automatic logic [3:0] alu_fn_sel(input logic [5:0] opc);
      if (opc[5:4] == OPC_CLASS_OP || opc[5:4] == OPC_CLASS_OPC) begin
         return opc[3:0];
      end
      return FN_ADD;
   endfunction

   function automatic logic is_mul(input logic [5:0] opc);
      return alu_fn_sel(opc) == FN_MUL;
   endfunction

endpackage

// File: rtl/beta_alu_comb.sv
// -----------------------------------------------------------------------------
// beta_alu_comb
// Purely combinational Beta ALU (no multiplier; MUL and DIV return 0 here).
//   fn     in  4      ALU function code (alu_fn_e)
//   a, b   in  WIDTH  operands
//   result out WIDTH  function result; compares are zero-extended 0/1
// -----------------------------------------------------------------------------
module beta_alu_comb
   import beta_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       fn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   localparam int SW = $clog2(WIDTH);

   logic [SW-1:0] shamt;
   assign shamt = b[SW-1:0];

   always_comb begin
      result = '0;
      case (fn)
         FN_ADD:   result = a + b;
         FN_SUB:   result = a - b;
         FN_CMPEQ: result = {{(WIDTH-1){1'b0}}, (a == b)};
         FN_CMPLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
         FN_CMPLE: result = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
         FN_AND:   result = a & b;
         FN_OR:    result = a | b;
         FN_XOR:   result = a ^ b;
         FN_XNOR:  result = ~(a ^ b);
         FN_SHL:   result = a << shamt;
         FN_SHR:   result = a >> shamt;
         FN_SRA:   result = $signed(a) >>> shamt;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/beta_exe_stage.sv
// -----------------------------------------------------------------------------
// beta_exe_stage
// Beta execute pipeline stage with valid/ready handshake on both sides.
// Optional feature macro: BETA_EXE_MUL_EN (iterative shift-add multiplier).
//   clk, reset                  clock, synchronous active-high reset
//   irsrc[1:0]                  0 = irin, 1 = BNE trap, 2/3 = NOP bubble
//   in_valid / in_ready         upstream handshake; capture when in_ready
//   pcin, ain, bin, din, irin   captured fields
//   out_valid / out_ready       downstream handshake; outputs held while stalled
//   yout                        execute result
//   pcout, dout, irout          registered passthrough fields
//   busy                        multiplier iterating (0 without the macro)
//   illop                       MUL/MULC held with no multiplier (0 with macro)
// -----------------------------------------------------------------------------
module beta_exe_stage
   import beta_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       irsrc,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] pcin,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic [WIDTH-1:0] din,
   input  logic [31:0]      irin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] yout,
   output logic [WIDTH-1:0] pcout,
   output logic [WIDTH-1:0] dout,
   output logic [31:0]      irout,
   output logic             busy,
   output logic             illop
);

   logic [WIDTH-1:0] pc_q, a_q, b_q, d_q;
   logic [31:0]      ir_q, ir_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_w;
   logic             mul_start;
   logic             mul_done;
   logic [3:0]       fn;
   logic [WIDTH-1:0] alu_y;

   assign in_ready = !busy_w && (!out_valid_q || out_ready);

   // Instruction source selection; an invalid slot from upstream becomes a
   // NOP so stale instruction bits never reach the ALU decode.
   always_comb begin
      ir_d        = NOP;
      out_valid_d = 1'b1;
      case (irsrc)
         2'd0: begin
            ir_d        = in_valid ? irin : NOP;
            out_valid_d = in_valid;
         end
         2'd1:    ir_d = BNE;
         default: ir_d = NOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         d_q         <= '0;
         ir_q        <= NOP;
         out_valid_q <= 1'b0;
      end else if (in_ready) begin
         pc_q        <= pcin;
         a_q         <= ain;
         b_q         <= bin;
         d_q         <= din;
         ir_q        <= ir_d;
         // A multiply withholds out_valid until the product is complete.
         out_valid_q <= out_valid_d && !mul_start;
      end else if (mul_done) begin
         out_valid_q <= 1'b1;
      end
   end

   assign fn = alu_fn_sel(ir_q[31:26]);

   beta_alu_comb #(.WIDTH(WIDTH)) u_alu (
      .fn     (fn),
      .a      (a_q),
      .b      (b_q),
      .result (alu_y)
   );

`ifdef BETA_EXE_MUL_EN
   localparam int CW = $clog2(WIDTH);

   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] prod_q;
   logic [WIDTH-1:0] mcand_q;

   // Only a genuine upstream MUL starts iterating; trap/bubble overrides it.
   assign mul_start = in_ready && (irsrc == 2'd0) && in_valid && is_mul(irin[31:26]);
   assign mul_done  = busy_q && (cnt_q == CW'(WIDTH - 1));

   // One multiplier bit per cycle: multiplier bit cnt_q selects whether the
   // progressively left-shifted multiplicand is accumulated.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
      end else if (in_ready) begin
         busy_q  <= mul_start;
         cnt_q   <= '0;
         prod_q  <= '0;
         mcand_q <= ain;
      end else if (busy_q) begin
         if (b_q[cnt_q]) begin
            prod_q <= prod_q + mcand_q;
         end
         mcand_q <= mcand_q << 1;
         cnt_q   <= cnt_q + CW'(1);
         if (mul_done) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign busy_w = busy_q;
   assign yout   = is_mul(ir_q[31:26]) ? prod_q : alu_y;
   assign illop  = 1'b0;
`else
   assign mul_start = 1'b0;
   assign mul_done  = 1'b0;
   assign busy_w    = 1'b0;
   assign yout      = alu_y;
   // Downstream uses this to trap to ILLOP; only meaningful while valid.
   assign illop     = out_valid_q && is_mul(ir_q[31:26]);
`endif

   assign busy      = busy_w;
   assign out_valid = out_valid_q;
   assign pcout     = pc_q;
   assign dout      = d_q;
   assign irout     = ir_q;

endmodule
